// File: rtl/fft_frame_packer.sv
// Small first-word-fall-through FIFO used as the packer's elastic buffer.
// Latency: a write at edge t is visible on rd_dat after edge t (one cycle) when the FIFO was empty.
// Backpressure: wr_rdy drops when full; a write against a full FIFO is refused even if a read pops in the same cycle.
module fft_frame_packer_fifo #(
    parameter int W  = 17,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          empty;
    logic          do_wr;
    logic          do_rd;

    // Full/empty come from the registered occupancy, never from pointer compares.
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign do_wr  = wr_vld & ~full;
    assign do_rd  = rd_rdy & ~empty;
    assign wr_rdy = ~full;
    assign rd_vld = ~empty;
    // Head is forced to zero when empty so the outputs are clean out of reset.
    assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; simultaneous read and write leave occupancy unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end
endmodule

// Packs real DDS samples into complex AXI-Stream words cut into FRAME_LEN-sample frames for the FFT.
// Latency: one cycle from sample write to m_tdata when the buffer is empty.
// Backpressure: m_tready stalls fill the FIFO; a sample arriving while full is dropped, ovf set, and the frame is zero-padded.
module fft_frame_packer #(
    parameter int DATA_W    = 14,
    parameter int OUT_W     = 16,
    parameter int FRAME_LEN = 1024,
    parameter int LOG2_LEN  = 10,
    parameter int FIFO_AW   = 4
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    din,
    input  logic                 din_valid,
    input  logic                 enable,
    input  logic                 clr_ovf,
    output logic [2*OUT_W-1:0]   m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 ovf,
    output logic [15:0]          frame_cnt,
    output logic                 busy
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PAD     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LOG2_LEN-1:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                fifo_wr_vld;
    logic [OUT_W:0]      fifo_wr_dat;
    logic                fifo_wr_rdy;
    logic                fifo_rd_vld;
    logic [OUT_W:0]      fifo_rd_dat;
    logic                is_last;
    logic                drop;
    logic [OUT_W-1:0]    din_ext;

    assign is_last = (cnt_q == LOG2_LEN'(FRAME_LEN - 1));
    assign din_ext = {{(OUT_W-DATA_W){din[DATA_W-1]}}, din};

    // FSM next state, sample counter and FIFO write request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fifo_wr_vld = 1'b0;
        fifo_wr_dat = '0;
        drop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end
            end
            S_CAPTURE: begin
                if (din_valid) begin
                    if (fifo_wr_rdy) begin
                        fifo_wr_vld = 1'b1;
                        fifo_wr_dat = {is_last, din_ext};
                        cnt_d       = cnt_q + LOG2_LEN'(1);
                        if (is_last) begin
                            cnt_d   = '0;
                            state_d = enable ? S_CAPTURE : S_IDLE;
                        end
                    end else begin
                        // Dropped sample is not counted; the rest of the frame becomes padding.
                        drop    = 1'b1;
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (fifo_wr_rdy) begin
                    fifo_wr_vld = 1'b1;
                    fifo_wr_dat = {is_last, {OUT_W{1'b0}}};
                    cnt_d       = cnt_q + LOG2_LEN'(1);
                    if (is_last) begin
                        cnt_d   = '0;
                        state_d = enable ? S_CAPTURE : S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky overflow (a drop beats a simultaneous clear) and completed-frame counter.
    always_comb begin
        ovf_d       = ovf_q;
        frame_cnt_d = frame_cnt_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (fifo_rd_vld && m_tready && fifo_rd_dat[OUT_W]) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Control state registers.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fft_frame_packer_fifo #(
        .W  (OUT_W + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (sclk),
        .rst    (rst),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_dat (fifo_rd_dat),
        .rd_rdy (m_tready)
    );

    assign m_tvalid  = fifo_rd_vld;
    assign m_tlast   = fifo_rd_dat[OUT_W];
    assign m_tdata   = {{OUT_W{1'b0}}, fifo_rd_dat[OUT_W-1:0]};
    assign ovf       = ovf_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != S_IDLE) | fifo_rd_vld;
endmodule

// File: tb/tb_fft_frame_packer.sv
// Scoreboard bench for fft_frame_packer: stimulus pushes expected beats, a negedge monitor pops and compares.
// Latency: expected beats are checked at the handshake, independent of FIFO delay.
// Backpressure: m_tready is driven directly to create stalls, overflow and padding.
module tb_fft_frame_packer;
    logic        sclk;
    logic        rst;
    logic [13:0] din;
    logic        din_valid;
    logic        enable;
    logic        clr_ovf;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        ovf;
    logic [15:0] frame_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_dat[$];
    logic        exp_last[$];

    fft_frame_packer dut (
        .sclk      (sclk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .enable    (enable),
        .clr_ovf   (clr_ovf),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .ovf       (ovf),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        exp_dat.push_back(d);
        exp_last.push_back(l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_dat.delete();
        exp_last.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_dat.size() != 0 || m_tvalid) && k < 3000) begin
            step();
            k++;
        end
        chk(name, exp_dat.size(), 0);
    endtask

    task automatic wait_frames(input logic [15:0] n, input string name);
        int k;
        k = 0;
        while (frame_cnt != n && k < 3000) begin
            step();
            k++;
        end
        chk(name, {16'h0, frame_cnt}, {16'h0, n});
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge sclk) begin
        if (!rst && m_tvalid && m_tready) begin
            checks++;
            if (exp_dat.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data 0x%08h last %0b, expected no beat", m_tdata, m_tlast);
            end else begin
                logic [31:0] ed;
                logic        el;
                ed = exp_dat.pop_front();
                el = exp_last.pop_front();
                if (m_tdata !== ed || m_tlast !== el) begin
                    errors++;
                    $display("FAIL beat: got data 0x%08h last %0b, expected data 0x%08h last %0b",
                             m_tdata, m_tlast, ed, el);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        enable    = 1'b0;
        clr_ovf   = 1'b0;
        m_tready  = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);

        // Two full frames of a ramp, with the extreme codes at beats 5 and 6.
        enable = 1'b1;
        step();
        for (int i = 0; i < 2048; i++) begin
            din_valid = 1'b1;
            if (i == 5) begin
                din = 14'h2000;
                push(32'h0000E000, 1'b0);
            end else if (i == 6) begin
                din = 14'h1FFF;
                push(32'h00001FFF, 1'b0);
            end else begin
                din = 14'(i);
                push(32'(i), (i % 1024) == 1023);
            end
            step();
            if (i == 0) chk("latency_vld", m_tvalid, 1);
            if (i == 3) chk("latency_dat", m_tdata, 32'h3);
        end
        din_valid = 1'b0;
        wait_drain("ramp_drain");
        chk("ramp_frame_cnt", frame_cnt, 2);
        chk("ramp_ovf", ovf, 0);

        // Stall at sample 100: 16 buffered, sample 115 dropped with a same-cycle clear.
        do_reset();
        enable = 1'b1;
        step();
        for (int i = 0; i < 100; i++) begin
            din = 14'(i);
            din_valid = 1'b1;
            push(32'(i), 1'b0);
            step();
        end
        m_tready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            din = 14'(100 + k);
            din_valid = 1'b1;
            clr_ovf = (k == 15);
            if (k < 15) push(32'(100 + k), 1'b0);
            if (k == 15) begin
                for (int p = 115; p < 1024; p++) push(32'h0, p == 1023);
            end
            step();
            if (k == 14) chk("stall_ovf_before_drop", ovf, 0);
            if (k == 15) chk("ovf_set_wins", ovf, 1);
        end
        clr_ovf = 1'b0;
        din_valid = 1'b0;
        m_tready = 1'b1;
        wait_frames(16'd1, "pad_frame_cnt");
        chk("pad_queue_empty", exp_dat.size(), 0);
        chk("pad_ovf_sticky", ovf, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", ovf, 0);
        for (int i = 0; i < 8; i++) begin
            din = 14'(14'h3000 + i);
            din_valid = 1'b1;
            push(32'h0000F000 + 32'(i), 1'b0);
            step();
        end
        din_valid = 1'b0;
        wait_drain("live_after_pad");

        // Enable drops at sample 500; the frame completes and nothing else is written.
        do_reset();
        enable = 1'b1;
        step();
        for (int i = 0; i < 1024; i++) begin
            if (i == 500) enable = 1'b0;
            din = 14'(i);
            din_valid = 1'b1;
            push(32'(i), i == 1023);
            step();
            if (i == 600) chk("busy_mid_frame", busy, 1);
        end
        for (int k = 0; k < 30; k++) begin
            din = 14'h0155;
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        begin
            int k;
            k = 0;
            while (busy && k < 3000) begin
                step();
                k++;
            end
        end
        chk("busy_fall", busy, 0);
        chk("disable_frame_cnt", frame_cnt, 1);
        chk("disable_queue_empty", exp_dat.size(), 0);
        chk("disable_tvalid", m_tvalid, 0);

        // Asynchronous reset with 10 entries buffered.
        enable = 1'b1;
        step();
        m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = 14'(50 + i);
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        chk("prerst_tvalid", m_tvalid, 1);
        #2;
        rst = 1'b1;
        exp_dat.delete();
        exp_last.delete();
        enable = 1'b0;
        #1;
        chk("async_rst_tvalid", m_tvalid, 0);
        chk("async_rst_frame_cnt", frame_cnt, 0);
        chk("async_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        m_tready = 1'b1;
        enable = 1'b1;
        step();
        for (int i = 0; i < 1024; i++) begin
            din = 14'(i + 7);
            din_valid = 1'b1;
            push(32'(i + 7), i == 1023);
            step();
        end
        din_valid = 1'b0;
        wait_drain("post_rst_drain");
        chk("post_rst_frame_cnt", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
